// File: rtl/mem_pkg.sv
// Shared constants for the unified memory port: load/store size encodings,
// arbiter FSM state encoding and requester identifiers.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_ERR  = 2'd2;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_LS = 1'b1;

endpackage

// File: rtl/mem_port_arbiter_lsu_align.sv
// Byte-lane steering for a 32-bit word port: store byte enables and lane
// replication, load lane extraction with extension, and access legality.
module lsu_align
  import mem_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata_ext,
  output logic        err
);

  logic [31:0] shifted;

  always_comb begin
    shifted   = rdata >> {addr_lo, 3'b000};
    be        = 4'b0000;
    wdata_rep = wdata;
    rdata_ext = shifted;
    err       = 1'b0;
    case (funct3)
      F3_B, F3_BU: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        err       = we && (funct3 == F3_BU);
        rdata_ext = (funct3 == F3_B) ? {{24{shifted[7]}}, shifted[7:0]}
                                     : {24'd0, shifted[7:0]};
      end
      F3_H, F3_HU: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        err       = addr_lo[0] || (we && (funct3 == F3_HU));
        rdata_ext = (funct3 == F3_H) ? {{16{shifted[15]}}, shifted[15:0]}
                                     : {16'd0, shifted[15:0]};
      end
      F3_W: begin
        be  = 4'b1111;
        err = (addr_lo != 2'b00);
      end
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin sharing of one memory port between instruction fetch and the
// load/store path; one outstanding transaction, registered responses.
module mem_port_arbiter
  import mem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            if_req,
  input  logic [XLEN-1:0] if_addr,
  output logic            if_gnt,
  output logic            if_rvalid,
  output logic [XLEN-1:0] if_rdata,
  input  logic            ls_req,
  input  logic            ls_we,
  input  logic [2:0]      ls_funct3,
  input  logic [XLEN-1:0] ls_addr,
  input  logic [XLEN-1:0] ls_wdata,
  output logic            ls_gnt,
  output logic            ls_rvalid,
  output logic [XLEN-1:0] ls_rdata,
  output logic            ls_err,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [3:0]      mem_be,
  output logic [XLEN-1:0] mem_wdata,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata
);

  logic [1:0]      state_q, state_d;
  logic            ptr_q, ptr_d;
  logic            owner_q, owner_d;
  logic [2:0]      f3_q, f3_d;
  logic [1:0]      alo_q, alo_d;
  logic            mem_req_q, mem_req_d;
  logic            mem_we_q, mem_we_d;
  logic [XLEN-1:0] mem_addr_q, mem_addr_d;
  logic [3:0]      mem_be_q, mem_be_d;
  logic [XLEN-1:0] mem_wdata_q, mem_wdata_d;
  logic            if_rvalid_q, if_rvalid_d;
  logic [XLEN-1:0] if_rdata_q, if_rdata_d;
  logic            ls_rvalid_q, ls_rvalid_d;
  logic [XLEN-1:0] ls_rdata_q, ls_rdata_d;
  logic            ls_err_q, ls_err_d;

  logic            gnt_if, gnt_ls;
  logic [2:0]      al_f3;
  logic [1:0]      al_alo;
  logic [3:0]      al_be;
  logic [XLEN-1:0] al_wdata, al_rdata;
  logic            al_err;
  logic            if_addr_unused;

  assign if_addr_unused = ^if_addr[1:0];

  // One aligner serves both directions: incoming LS operands at accept time,
  // the latched access while waiting for the read word.
  assign al_f3  = (state_q == ST_BUSY) ? f3_q  : ls_funct3;
  assign al_alo = (state_q == ST_BUSY) ? alo_q : ls_addr[1:0];

  lsu_align u_align (
    .we        (ls_we),
    .funct3    (al_f3),
    .addr_lo   (al_alo),
    .wdata     (ls_wdata),
    .rdata     (mem_rdata),
    .be        (al_be),
    .wdata_rep (al_wdata),
    .rdata_ext (al_rdata),
    .err       (al_err)
  );

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    owner_d     = owner_q;
    f3_d        = f3_q;
    alo_d       = alo_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = '0;
    ls_rvalid_d = 1'b0;
    ls_rdata_d  = '0;
    ls_err_d    = 1'b0;
    gnt_if      = 1'b0;
    gnt_ls      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ls_req && (!if_req || ptr_q == REQ_LS)) gnt_ls = 1'b1;
        else if (if_req)                            gnt_if = 1'b1;

        if (gnt_if) begin
          owner_d     = REQ_IF;
          ptr_d       = REQ_LS;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = {if_addr[XLEN-1:2], 2'b00};
          mem_be_d    = 4'b1111;
          mem_wdata_d = '0;
          state_d     = ST_BUSY;
        end else if (gnt_ls) begin
          owner_d     = REQ_LS;
          ptr_d       = REQ_IF;
          f3_d        = ls_funct3;
          alo_d       = ls_addr[1:0];
          mem_we_d    = ls_we;
          mem_addr_d  = {ls_addr[XLEN-1:2], 2'b00};
          mem_be_d    = al_be;
          mem_wdata_d = al_wdata;
          if (al_err) begin
            mem_req_d   = 1'b0;
            ls_rvalid_d = 1'b1;
            ls_err_d    = 1'b1;
            state_d     = ST_ERR;
          end else begin
            mem_req_d = 1'b1;
            state_d   = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (mem_ready) begin
          mem_req_d = 1'b0;
          state_d   = ST_IDLE;
          if (owner_q == REQ_IF) begin
            if_rvalid_d = 1'b1;
            if_rdata_d  = mem_rdata;
          end else begin
            ls_rvalid_d = 1'b1;
            ls_rdata_d  = mem_we_q ? '0 : al_rdata;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Every output is cleared by reset, so the data path is reset as well.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ptr_q       <= REQ_LS;
      owner_q     <= REQ_IF;
      f3_q        <= '0;
      alo_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rvalid_q <= 1'b0;
      ls_rdata_q  <= '0;
      ls_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      f3_q        <= f3_d;
      alo_q       <= alo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      ls_rvalid_q <= ls_rvalid_d;
      ls_rdata_q  <= ls_rdata_d;
      ls_err_q    <= ls_err_d;
    end
  end

  // Grants are combinational so the accept edge is the one that latches mem_*.
  assign if_gnt    = gnt_if && rst_n;
  assign ls_gnt    = gnt_ls && rst_n;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rvalid = ls_rvalid_q;
  assign ls_rdata  = ls_rdata_q;
  assign ls_err    = ls_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_be    = mem_be_q;
  assign mem_wdata = mem_wdata_q;

endmodule
